alu_writeback: RTL

//   Write-back end of the register-file/ALU datapath: accepts ALU results and commits them to the register file write port.

---
 rtl/alu_wb_pkg.sv | 48 ++++
 rtl/alu_writeback_fifo.sv | 58 +++++
 rtl/alu_writeback.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_wb_pkg.sv
// alu_wb_pkg: shared definitions for the ALU write-back block.
//   - Drain FSM state encodings (IDLE / WR_LO / WR_HI).
//   - Write-back FIFO entry layout: field offsets and total entry width.
// Configuration macro: WB_FLAGS_EN (adds flagc/flagz to every FIFO entry).
// Entry layout, LSB first: result | dest_lo | dest_hi | wide [| flagc | flagz]
package alu_wb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WR_LO = 2'd1;
  localparam logic [1:0] ST_WR_HI = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    WR_LO = ST_WR_LO,
    WR_HI = ST_WR_HI
  } wb_state_t;

`ifdef WB_FLAGS_EN
  localparam int unsigned FLAG_BITS = 2;
`else
  localparam int unsigned FLAG_BITS = 0;
`endif

  function automatic int unsigned off_dest_lo(input int unsigned dw);
    return 2 * dw;
  endfunction

  function automatic int unsigned off_dest_hi(input int unsigned dw, input int unsigned aw);
    return 2 * dw + aw;
  endfunction

  function automatic int unsigned off_wide(input int unsigned dw, input int unsigned aw);
    return 2 * dw + 2 * aw;
  endfunction

  function automatic int unsigned off_flagc(input int unsigned dw, input int unsigned aw);
    return 2 * dw + 2 * aw + 1;
  endfunction

  function automatic int unsigned off_flagz(input int unsigned dw, input int unsigned aw);
    return 2 * dw + 2 * aw + 2;
  endfunction

  function automatic int unsigned entry_w(input int unsigned dw, input int unsigned aw);
    return 2 * dw + 2 * aw + 1 + FLAG_BITS;
  endfunction

endpackage

// File: rtl/alu_writeback_fifo.sv
// wb_fifo: synchronous FIFO with read/write pointers and an occupancy count.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset (empties FIFO)
//   push/wdata write request; ignored while full
//   pop        read request; ignored while empty
//   rdata      head entry (valid while !empty)
//   full/empty occupancy flags
//   count      current number of entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: write-back end of the ALU / register-file datapath.
// Queues ALU results in a small FIFO and drains them one register write per
// cycle: dest_lo <= result[DATA_W-1:0], then (if wide) dest_hi <= upper half.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  request handshake (in_ready = !full, registered)
//   result          2*DATA_W ALU result
//   dest_lo/hi      destination registers for low/high halves
//   wide            1: write both halves, 0: low half only
//   flagc/flagz     ALU flags, stored only with WB_FLAGS_EN
//   ip_1/sel_i1     reg-file write data / select
//   en/wr           reg-file enable / write strobe
//   busy            FIFO non-empty or FSM not idle
//   done            pulse with the last write of each request
//   stat_c/stat_z   committed flags (constant 0 without WB_FLAGS_EN)
// Configuration macro: WB_FLAGS_EN.
module alu_writeback
  import alu_wb_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] result,
  input  logic [ADDR_W-1:0]   dest_lo,
  input  logic [ADDR_W-1:0]   dest_hi,
  input  logic                wide,
  input  logic                flagc,
  input  logic                flagz,
  output logic [DATA_W-1:0]   ip_1,
  output logic [ADDR_W-1:0]   sel_i1,
  output logic                en,
  output logic                wr,
  output logic                busy,
  output logic                done,
  output logic                stat_c,
  output logic                stat_z
);

  localparam int unsigned RES_W  = 2 * DATA_W;
  localparam int unsigned EW     = entry_w(DATA_W, ADDR_W);
  localparam int unsigned O_LO   = off_dest_lo(DATA_W);
  localparam int unsigned O_HI   = off_dest_hi(DATA_W, ADDR_W);
  localparam int unsigned O_WIDE = off_wide(DATA_W, ADDR_W);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [EW-1:0]     wdata;
  logic [EW-1:0]     head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_n;
  logic              push;
  logic              pop;
  wb_state_t         state;
  wb_state_t         state_n;

  logic [RES_W-1:0]  h_result;
  logic [ADDR_W-1:0] h_lo;
  logic [ADDR_W-1:0] h_hi;
  logic              h_wide;

`ifdef WB_FLAGS_EN
  assign wdata = {flagz, flagc, wide, dest_hi, dest_lo, result};
`else
  logic unused_flags;
  assign unused_flags = flagc ^ flagz;
  assign wdata = {wide, dest_hi, dest_lo, result};
`endif

  assign h_result = head[RES_W-1:0];
  assign h_lo     = head[O_LO +: ADDR_W];
  assign h_hi     = head[O_HI +: ADDR_W];
  assign h_wide   = head[O_WIDE];

  // in_ready is registered from the post-edge occupancy, so it always equals
  // !full and a same-cycle pop never frees space for the current push.
  assign push    = in_valid && in_ready;
  assign count_n = fifo_count + CNT_W'(push) - CNT_W'(pop);

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  logic unused_full;
  assign unused_full = fifo_full;

  // The head is popped on the cycle its last write is registered, so the
  // next entry is already at the head when the FSM stays in WR_LO.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_n = WR_LO;
      end
      WR_LO: begin
        if (h_wide) begin
          state_n = WR_HI;
        end else begin
          pop     = 1'b1;
          state_n = (fifo_count > CNT_W'(1)) ? WR_LO : IDLE;
        end
      end
      WR_HI: begin
        pop     = 1'b1;
        state_n = (fifo_count > CNT_W'(1)) ? WR_LO : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ip_1     <= '0;
      sel_i1   <= '0;
      en       <= 1'b0;
      wr       <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_n;
      busy     <= (state_n != IDLE) || (count_n != '0);
      in_ready <= (count_n != CNT_W'(FIFO_DEPTH));
      en       <= 1'b0;
      wr       <= 1'b0;
      done     <= 1'b0;
      case (state)
        WR_LO: begin
          en     <= 1'b1;
          wr     <= 1'b1;
          sel_i1 <= h_lo;
          ip_1   <= h_result[DATA_W-1:0];
          done   <= !h_wide;
        end
        WR_HI: begin
          en     <= 1'b1;
          wr     <= 1'b1;
          sel_i1 <= h_hi;
          ip_1   <= h_result[RES_W-1:DATA_W];
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef WB_FLAGS_EN
  localparam int unsigned O_FC = off_flagc(DATA_W, ADDR_W);
  localparam int unsigned O_FZ = off_flagz(DATA_W, ADDR_W);

  // pop coincides with the done cycle of the head entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_c <= 1'b0;
      stat_z <= 1'b0;
    end else if (pop) begin
      stat_c <= head[O_FC];
      stat_z <= head[O_FZ];
    end
  end
`else
  assign stat_c = 1'b0;
  assign stat_z = 1'b0;
`endif

endmodule
